// File: rtl/keccak_share_io.sv
// Host-side loader/unloader for the two-share masked Keccak-f[1600] core; shares never meet.
// Optional build macro SHARE_REFRESH_EN adds s_mask_i, XORed into both shares of each accepted lane.
module keccak_share_io #(
   parameter int LANE_W    = 64,
   parameter int OUT_LANES = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [LANE_W-1:0]     s_lane_share0_i,
   input  logic [LANE_W-1:0]     s_lane_share1_i,
`ifdef SHARE_REFRESH_EN
   input  logic [LANE_W-1:0]     s_mask_i,
`endif
   output logic                  core_start_o,
   output logic [25*LANE_W-1:0]  core_din_share0_o,
   output logic [25*LANE_W-1:0]  core_din_share1_o,
   input  logic [25*LANE_W-1:0]  core_dout_share0_i,
   input  logic [25*LANE_W-1:0]  core_dout_share1_i,
   input  logic                  core_dout_vld_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [LANE_W-1:0]     m_lane_share0_o,
   output logic [LANE_W-1:0]     m_lane_share1_o,
   output logic                  m_last_o,
   output logic                  busy_o
);

   localparam int                N_LANES  = 25;
   localparam int                CNT_W    = 5;
   localparam logic [CNT_W-1:0]  LAST_IN  = 5'd24;
   localparam logic [CNT_W-1:0]  LAST_OUT = CNT_W'(OUT_LANES - 1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
   logic [LANE_W-1:0]    din0_q [N_LANES];
   logic [LANE_W-1:0]    din0_d [N_LANES];
   logic [LANE_W-1:0]    din1_q [N_LANES];
   logic [LANE_W-1:0]    din1_d [N_LANES];
   logic [LANE_W-1:0]    dout0_q [N_LANES];
   logic [LANE_W-1:0]    dout0_d [N_LANES];
   logic [LANE_W-1:0]    dout1_q [N_LANES];
   logic [LANE_W-1:0]    dout1_d [N_LANES];
   logic                 s_ready_q, s_ready_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 m_valid_q, m_valid_d;
   logic                 m_last_q, m_last_d;
   logic [LANE_W-1:0]    m_lane0_q, m_lane0_d;
   logic [LANE_W-1:0]    m_lane1_q, m_lane1_d;

   logic [LANE_W-1:0]    lane0_s;
   logic [LANE_W-1:0]    lane1_s;
   logic [CNT_W-1:0]     out_nxt_s;
   logic                 in_hs_s;
   logic                 out_hs_s;

`ifdef SHARE_REFRESH_EN
   assign lane0_s = s_lane_share0_i ^ s_mask_i;
   assign lane1_s = s_lane_share1_i ^ s_mask_i;
`else
   assign lane0_s = s_lane_share0_i;
   assign lane1_s = s_lane_share1_i;
`endif

   assign in_hs_s   = s_valid_i & s_ready_q;
   assign out_hs_s  = m_valid_q & m_ready_i;
   // Clamp keeps the look-ahead index inside the 25-entry array on the final lane.
   assign out_nxt_s = (out_cnt_q == LAST_IN) ? out_cnt_q : out_cnt_q + 5'd1;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      din0_d    = din0_q;
      din1_d    = din1_q;
      dout0_d   = dout0_q;
      dout1_d   = dout1_q;
      m_last_d  = m_last_q;
      m_lane0_d = m_lane0_q;
      m_lane1_d = m_lane1_q;

      case (state_q)
         ST_LOAD: begin
            if (in_hs_s) begin
               din0_d[in_cnt_q] = lane0_s;
               din1_d[in_cnt_q] = lane1_s;
               if (in_cnt_q == LAST_IN) begin
                  in_cnt_d = 5'd0;
                  state_d  = ST_START;
               end else begin
                  in_cnt_d = in_cnt_q + 5'd1;
               end
            end else begin
               in_cnt_d = in_cnt_q;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_dout_vld_i) begin
               for (int i = 0; i < N_LANES; i++) begin
                  dout0_d[i] = core_dout_share0_i[i*LANE_W +: LANE_W];
                  dout1_d[i] = core_dout_share1_i[i*LANE_W +: LANE_W];
               end
               out_cnt_d = 5'd0;
               m_lane0_d = core_dout_share0_i[LANE_W-1:0];
               m_lane1_d = core_dout_share1_i[LANE_W-1:0];
               m_last_d  = (LAST_OUT == 5'd0);
               state_d   = ST_UNLOAD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_UNLOAD: begin
            if (out_hs_s) begin
               if (out_cnt_q == LAST_OUT) begin
                  out_cnt_d = 5'd0;
                  m_lane0_d = '0;
                  m_lane1_d = '0;
                  m_last_d  = 1'b0;
                  state_d   = ST_LOAD;
               end else begin
                  out_cnt_d = out_nxt_s;
                  m_lane0_d = dout0_q[out_nxt_s];
                  m_lane1_d = dout1_q[out_nxt_s];
                  m_last_d  = (out_nxt_s == LAST_OUT);
               end
            end else begin
               out_cnt_d = out_cnt_q;
            end
         end
         default: begin
            state_d   = ST_LOAD;
            in_cnt_d  = 5'd0;
            out_cnt_d = 5'd0;
         end
      endcase

      s_ready_d = (state_d == ST_LOAD);
      start_d   = (state_d == ST_START);
      busy_d    = (state_d != ST_LOAD);
      m_valid_d = (state_d == ST_UNLOAD);
   end

   // Control state and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LOAD;
         in_cnt_q  <= 5'd0;
         out_cnt_q <= 5'd0;
         s_ready_q <= 1'b1;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_lane0_q <= '0;
         m_lane1_q <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         s_ready_q <= s_ready_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_lane0_q <= m_lane0_d;
         m_lane1_q <= m_lane1_d;
      end
   end

   // Per-share state storage: input state to the core and captured result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LANES; i++) begin
            din0_q[i]  <= '0;
            din1_q[i]  <= '0;
            dout0_q[i] <= '0;
            dout1_q[i] <= '0;
         end
      end else begin
         din0_q  <= din0_d;
         din1_q  <= din1_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
      end
   end

   for (genvar g = 0; g < N_LANES; g++) begin : g_pack
      assign core_din_share0_o[g*LANE_W +: LANE_W] = din0_q[g];
      assign core_din_share1_o[g*LANE_W +: LANE_W] = din1_q[g];
   end

   assign s_ready_o       = s_ready_q;
   assign core_start_o    = start_q;
   assign busy_o          = busy_q;
   assign m_valid_o       = m_valid_q;
   assign m_last_o        = m_last_q;
   assign m_lane_share0_o = m_lane0_q;
   assign m_lane_share1_o = m_lane1_q;

endmodule
